// File: rtl/vx_mem_responder.sv
// Line-granular memory model: byte-enabled writes, fixed-latency in-order reads.
// Optional MEM_RESPONDER_WR_ACK_EN: writes also return a zero-data response.
module vx_mem_responder #(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned TAG_WIDTH      = 8,
  parameter int unsigned RAM_ADDR_WIDTH = 10,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned QUEUE_DEPTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy
);

  localparam int unsigned ByteCount   = DATA_WIDTH / 8;
  localparam int unsigned RamDepth    = 2 ** RAM_ADDR_WIDTH;
  localparam int unsigned PtrWidth    = $clog2(QUEUE_DEPTH);
  localparam int unsigned CreditWidth = PtrWidth + 1;

  logic [DATA_WIDTH-1:0]     store_q [RamDepth];
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic [DATA_WIDTH-1:0]     rd_word;

  logic req_fire;
  logic rsp_fire;
  logic wr_fire;
  logic rsp_req;
  logic [DATA_WIDTH-1:0] pipe_in_data;

  logic                   ready_en_q;
  logic [CreditWidth-1:0] credit_q;
  logic [CreditWidth-1:0] credit_d;

  logic [LATENCY-1:0]    pipe_valid_q;
  logic [DATA_WIDTH-1:0] pipe_data_q [LATENCY];
  logic [TAG_WIDTH-1:0]  pipe_tag_q  [LATENCY];

  logic [DATA_WIDTH-1:0] fifo_data_q [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag_q  [QUEUE_DEPTH];
  logic [PtrWidth:0]     wr_ptr_q;
  logic [PtrWidth:0]     rd_ptr_q;
  logic                  fifo_push;
  logic                  fifo_empty;
  logic                  fifo_full;

  logic unused_addr;
  assign unused_addr = ^mem_req_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign req_fire = mem_req_valid && mem_req_ready;
  assign rsp_fire = mem_rsp_valid && mem_rsp_ready;
  assign wr_fire  = req_fire && mem_req_rw;
  assign ram_idx  = mem_req_addr[RAM_ADDR_WIDTH-1:0];
  assign rd_word  = store_q[ram_idx];

`ifdef MEM_RESPONDER_WR_ACK_EN
  assign rsp_req      = req_fire;
  assign pipe_in_data = mem_req_rw ? '0 : rd_word;
`else
  assign rsp_req      = req_fire && !mem_req_rw;
  assign pipe_in_data = rd_word;
`endif

  // Ready only opens on the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  assign mem_req_ready = ready_en_q && (credit_q < CreditWidth'(QUEUE_DEPTH));
  assign busy          = (credit_q != '0);

  // ---------------------------------------------------------------------------
  // Backing store (contents survive reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < ByteCount; i++) begin
        if (mem_req_byteen[i]) begin
          store_q[ram_idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Credits: one per response-producing request until its response fires
  // ---------------------------------------------------------------------------
  always_comb begin
    credit_d = credit_q;
    if (rsp_req && !rsp_fire) begin
      credit_d = credit_q + CreditWidth'(1);
    end else if (!rsp_req && rsp_fire) begin
      credit_d = credit_q - CreditWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Fixed-latency read pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid_q <= '0;
    end else begin
      pipe_valid_q[0] <= rsp_req;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_data_q[0] <= pipe_in_data;
    pipe_tag_q[0]  <= mem_req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data_q[i] <= pipe_data_q[i-1];
      pipe_tag_q[i]  <= pipe_tag_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO; extra pointer bit distinguishes full from empty
  // ---------------------------------------------------------------------------
  assign fifo_push  = pipe_valid_q[LATENCY-1];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]) &&
                      (wr_ptr_q[PtrWidth-1:0] == rd_ptr_q[PtrWidth-1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + (PtrWidth+1)'(1);
      end
      if (rsp_fire) begin
        rd_ptr_q <= rd_ptr_q + (PtrWidth+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data_q[wr_ptr_q[PtrWidth-1:0]] <= pipe_data_q[LATENCY-1];
      fifo_tag_q[wr_ptr_q[PtrWidth-1:0]]  <= pipe_tag_q[LATENCY-1];
    end
  end

  assign mem_rsp_valid = !fifo_empty;
  assign mem_rsp_data  = fifo_data_q[rd_ptr_q[PtrWidth-1:0]];
  assign mem_rsp_tag   = fifo_tag_q[rd_ptr_q[PtrWidth-1:0]];

`ifndef SYNTHESIS
  // Credit accounting must make these unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_push && fifo_full));
  a_credit_range: assert property (@(posedge clk) disable iff (!reset_n)
    credit_q <= CreditWidth'(QUEUE_DEPTH));
  a_no_pop_without_credit: assert property (@(posedge clk) disable iff (!reset_n)
    !(rsp_fire && credit_q == '0));
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder (default parameters); responses are
// captured in a queue and compared against hand-computed tag/data pairs.
module tb_vx_mem_responder;

  localparam int DW  = 512;
  localparam int AW  = 26;
  localparam int TW  = 8;
  localparam int LAT = 4;
  localparam int QD  = 8;

  localparam logic [DW-1:0] DataA  = {8{64'h0123_4567_89AB_CDEF}};
  localparam logic [DW-1:0] AllAA  = {64{8'hAA}};
  localparam logic [DW-1:0] All55  = {64{8'h55}};
  localparam logic [DW-1:0] Mix55  = {{63{8'hAA}}, 8'h55};
  localparam logic [DW-1:0] DataB  = {16{32'hC0FF_EE11}};
  localparam logic [63:0]   BeAll  = {64{1'b1}};

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [63:0]   mem_req_byteen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready;
  logic          busy;

  int n_vec = 0;
  int n_miscmp = 0;
  logic [TW+DW-1:0] rsp_q[$];

  always #5 clk = ~clk;

  vx_mem_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .busy           (busy)
  );

  // Inputs change #1 after posedge, so the negedge sees the final handshake.
  always @(negedge clk) begin
    if (reset_n && mem_rsp_valid && mem_rsp_ready) begin
      rsp_q.push_back({mem_rsp_tag, mem_rsp_data});
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rw, input logic [AW-1:0] addr, input logic [63:0] be,
                      input logic [DW-1:0] data, input logic [TW-1:0] tag);
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_byteen = be;
    mem_req_data   = data;
    mem_req_tag    = tag;
    for (int i = 0; i < 50 && !mem_req_ready; i++) tick();
    if (!mem_req_ready) check("send_ready_timeout", mem_req_ready, 1);
    tick();
    mem_req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [TW-1:0] t, input logic [DW-1:0] d);
    logic [TW+DW-1:0] e;
    for (int i = 0; i < 40 && rsp_q.size() == 0; i++) tick();
    check({tag, "_present"}, (rsp_q.size() != 0), 1);
    if (rsp_q.size() == 0) return;
    e = rsp_q.pop_front();
    check({tag, "_tag"}, e[TW+DW-1:DW], t);
    check({tag, "_data"}, e[DW-1:0], d);
  endtask

  // Write acknowledgements only exist when the write-ack feature is built in.
  task automatic expect_ack(input string tag, input logic [TW-1:0] t);
`ifdef MEM_RESPONDER_WR_ACK_EN
    expect_rsp(tag, t, '0);
`else
    check({tag, "_no_ack"}, rsp_q.size(), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] nxt;
    logic          r;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_byteen = '0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b0;
    reset_n        = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_ready", mem_req_ready, 0);
    check("rst_rsp_valid", mem_rsp_valid, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    check("ready_before_edge", mem_req_ready, 0);
    tick();
    check("ready_after_edge", mem_req_ready, 1);

    // Write then read same line next cycle; check exact latency.
    send(1'b1, 26'h5, BeAll, DataA, 8'h11);
    send(1'b0, 26'h5, '0, '0, 8'h22);
`ifndef MEM_RESPONDER_WR_ACK_EN
    check("busy_after_read", busy, 1);
    for (int k = 1; k < LAT; k++) begin
      tick();
      check("lat_early", mem_rsp_valid, 0);
    end
    tick();
    check("lat_hit", mem_rsp_valid, 1);
    check("lat_hit_tag", mem_rsp_tag, 8'h22);
    check("lat_hit_data", mem_rsp_data, DataA);
    mem_rsp_ready = 1'b1;
    expect_rsp("raw", 8'h22, DataA);
    repeat (8) tick();
    check("no_wr_rsp", rsp_q.size(), 0);
    check("idle_busy", busy, 0);
`else
    for (int k = 1; k < LAT - 1; k++) begin
      tick();
      check("ack_lat_early", mem_rsp_valid, 0);
    end
    tick();
    check("ack_lat_hit", mem_rsp_valid, 1);
    mem_rsp_ready = 1'b1;
    expect_rsp("ack_raw", 8'h11, '0);
    expect_rsp("raw", 8'h22, DataA);
`endif
    mem_rsp_ready = 1'b1;

    // Partial byte write, zero byte-enable write, and address aliasing.
    send(1'b1, 26'h7, BeAll, AllAA, 8'h01);
    send(1'b1, 26'h7, 64'h1, All55, 8'h02);
    send(1'b0, 26'h7, '0, '0, 8'h03);
    expect_ack("ack1", 8'h01);
    expect_ack("ack2", 8'h02);
    expect_rsp("byteen", 8'h03, Mix55);
    send(1'b1, 26'h7, '0, '0, 8'h04);
    send(1'b0, 26'h7, '0, '0, 8'h05);
    expect_ack("ack4", 8'h04);
    expect_rsp("be_zero", 8'h05, Mix55);
    send(1'b1, 26'h409, BeAll, DataB, 8'h06);
    send(1'b0, 26'h9, '0, '0, 8'h07);
    expect_ack("ack6", 8'h06);
    expect_rsp("alias", 8'h07, DataB);

    // Back-pressure: only QD reads accepted while responses are held.
    mem_rsp_ready = 1'b0;
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 26'h5;
    for (int i = 0; i < QD; i++) begin
      mem_req_tag = TW'(i);
      check("bp_ready_open", mem_req_ready, 1);
      tick();
    end
    mem_req_tag = 8'd8;
    check("bp_ready_closed", mem_req_ready, 0);
    check("bp_credits_full", dut.credit_q, QD);
    repeat (LAT + 2) tick();
    check("bp_rsp_valid", mem_rsp_valid, 1);
    check("bp_ready_still_low", mem_req_ready, 0);
    mem_rsp_ready = 1'b1;
    nxt = 8'd8;
    for (int c = 0; c < 40; c++) begin
      r = mem_req_ready;
      tick();
      if (mem_req_valid && r) begin
        if (nxt == 8'd8) begin
          nxt = 8'd9;
          mem_req_tag = 8'd9;
        end else begin
          mem_req_valid = 1'b0;
        end
      end
    end
    check("bp_late_accepted", mem_req_valid, 0);
    for (int i = 0; i < 10; i++) expect_rsp("bp_order", TW'(i), DataA);
    check("bp_idle_busy", busy, 0);

    // Simultaneous request and response fire keeps the credit count.
    mem_rsp_ready = 1'b0;
    mem_req_valid = 1'b1;
    mem_req_addr  = 26'h5;
    for (int i = 0; i < 3; i++) begin
      mem_req_tag = TW'(8'h20 + i);
      tick();
    end
    mem_req_valid = 1'b0;
    repeat (LAT + 1) tick();
    check("sim_credits_before", dut.credit_q, 3);
    mem_rsp_ready = 1'b1;
    mem_req_valid = 1'b1;
    mem_req_tag   = 8'h23;
    check("sim_both_ready", {mem_req_ready, mem_rsp_valid}, 2'b11);
    tick();
    mem_req_valid = 1'b0;
    check("sim_credits_after", dut.credit_q, 3);
    for (int i = 0; i < 4; i++) expect_rsp("sim_order", TW'(8'h20 + i), DataA);

    // Reset with reads in flight drops them; store contents survive.
    mem_rsp_ready = 1'b0;
    mem_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_req_tag = TW'(8'h30 + i);
      tick();
    end
    mem_req_valid = 1'b0;
    repeat (LAT + 1) tick();
    check("inflight_valid", mem_rsp_valid, 1);
    reset_n = 1'b0;
    #1;
    check("async_rsp_valid", mem_rsp_valid, 0);
    check("async_busy", busy, 0);
    check("async_ready", mem_req_ready, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    mem_rsp_ready = 1'b1;
    repeat (12) tick();
    check("no_stale_rsp", rsp_q.size(), 0);
    check("post_rst_busy", busy, 0);
    send(1'b0, 26'h5, '0, '0, 8'h35);
    expect_rsp("store_kept", 8'h35, DataA);

`ifdef MEM_RESPONDER_WR_ACK_EN
    send(1'b1, 26'h8, BeAll, DataB, 8'h33);
    send(1'b0, 26'h8, '0, '0, 8'h34);
    expect_rsp("wrack_first", 8'h33, '0);
    expect_rsp("wrack_second", 8'h34, DataB);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
